// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with a general register file,
// two's-complement flags and a serial shifter / shift-add multiplier.
//
// Handshake: an operation is accepted on a rising Clk edge where
// OpValid=1 and OpReady=1; OpReady is high only in IDLE. OpCode, RegSel and
// InData are sampled at acceptance only. OpValid while busy is ignored, so the
// requester must hold it. OpDone pulses for the one cycle after the edge that
// commits the accepted operation's results.
module alu_mc #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              OpValid,
  output logic              OpReady,
  input  logic [4:0]        OpCode,
  input  logic [SEL_W-1:0]  RegSel,
  input  logic [DATA_W-1:0] InData,
  output logic              OpDone,
  output logic [DATA_W-1:0] OutData,
  output logic              OutValid,
  output logic [DATA_W-1:0] Index_Reg,
  output logic              FlagZ,
  output logic              FlagC,
  output logic              FlagN,
  output logic              FlagE,
  output logic [1:0]        DbgState
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;

  localparam logic [4:0] OP_NOP      = 5'd0;
  localparam logic [4:0] OP_LDR      = 5'd1;
  localparam logic [4:0] OP_LDACC    = 5'd2;
  localparam logic [4:0] OP_LDID     = 5'd3;
  localparam logic [4:0] OP_MVACC2R  = 5'd4;
  localparam logic [4:0] OP_MVACC2ID = 5'd5;
  localparam logic [4:0] OP_ADD      = 5'd6;
  localparam logic [4:0] OP_SUB      = 5'd7;
  localparam logic [4:0] OP_AND      = 5'd8;
  localparam logic [4:0] OP_OR       = 5'd9;
  localparam logic [4:0] OP_XOR      = 5'd10;
  localparam logic [4:0] OP_CMPE     = 5'd11;
  localparam logic [4:0] OP_CMPL     = 5'd12;
  localparam logic [4:0] OP_CMPG     = 5'd13;
  localparam logic [4:0] OP_SHL      = 5'd14;
  localparam logic [4:0] OP_SHR      = 5'd15;
  localparam logic [4:0] OP_MUL      = 5'd16;
  localparam logic [4:0] OP_OEACC    = 5'd17;
  localparam logic [4:0] OP_CLRE     = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t               state;
  logic [DATA_W-1:0]    regs [NREGS];
  logic [DATA_W-1:0]    acc;
  logic [DATA_W-1:0]    index_q;
  logic [DATA_W-1:0]    work;      // shifter working copy of Acc
  logic [DATA_W-1:0]    mcand;     // multiplicand (A) held during MUL
  logic [2*DATA_W-1:0]  prod;      // {partial high, remaining multiplier}
  logic [CNT_W-1:0]     cnt;       // remaining iterations
  logic                 shl_dir;   // 1: shift left, 0: shift right

  logic                 accept;
  logic [DATA_W-1:0]    op_a;
  logic [DATA_W-1:0]    op_b;
  logic [DATA_W:0]      add_sum;
  logic [SH_W-1:0]      sh_amt;
  logic [DATA_W-1:0]    work_sh;
  logic                 sh_out;
  logic [DATA_W:0]      mul_sum;
  logic [2*DATA_W-1:0]  prod_nx;

  assign OpReady   = (state == S_IDLE);
  assign accept    = OpValid && OpReady;
  assign op_a      = regs[0];
  assign op_b      = regs[RegSel];
  assign add_sum   = {1'b0, op_a} + {1'b0, op_b};
  assign sh_amt    = InData[SH_W-1:0];
  assign Index_Reg = index_q;
  assign DbgState  = state;

  // One-bit shift step of the working copy and the bit leaving it.
  always_comb begin
    work_sh = shl_dir ? {work[DATA_W-2:0], 1'b0} : {1'b0, work[DATA_W-1:1]};
    sh_out  = shl_dir ? work[DATA_W-1] : work[0];
  end

  // One shift-add multiply step: add A to the high half when the current
  // multiplier LSB is set, then shift the whole product right by one.
  always_comb begin
    mul_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nx = {mul_sum, prod[DATA_W-1:1]};
  end

  // Control FSM, architectural state and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      acc      <= '0;
      index_q  <= '0;
      work     <= '0;
      mcand    <= '0;
      prod     <= '0;
      cnt      <= '0;
      shl_dir  <= 1'b0;
      FlagZ    <= 1'b0;
      FlagC    <= 1'b0;
      FlagN    <= 1'b0;
      FlagE    <= 1'b0;
      OpDone   <= 1'b0;
      OutData  <= '0;
      OutValid <= 1'b0;
    end else begin
      OpDone   <= 1'b0;
      OutData  <= '0;
      OutValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Single-cycle ops commit here; multi-cycle starts clear this.
            OpDone <= 1'b1;
            case (OpCode)
              OP_NOP: ;
              OP_LDR:      regs[RegSel] <= InData;
              OP_LDACC:    acc <= InData;
              OP_LDID:     index_q <= InData;
              OP_MVACC2R:  regs[RegSel] <= acc;
              OP_MVACC2ID: index_q <= acc;
              OP_ADD: begin
                acc   <= add_sum[DATA_W-1:0];
                FlagC <= add_sum[DATA_W];
                FlagZ <= ~|add_sum[DATA_W-1:0];
                FlagN <= add_sum[DATA_W-1];
              end
              OP_SUB: begin
                acc   <= op_a - op_b;
                FlagC <= (op_a < op_b);
                FlagZ <= (op_a == op_b);
                FlagN <= (op_a - op_b) >> (DATA_W - 1) != '0;
              end
              OP_AND: begin
                acc   <= op_a & op_b;
                FlagC <= 1'b0;
                FlagZ <= ~|(op_a & op_b);
                FlagN <= op_a[DATA_W-1] & op_b[DATA_W-1];
              end
              OP_OR: begin
                acc   <= op_a | op_b;
                FlagC <= 1'b0;
                FlagZ <= ~|(op_a | op_b);
                FlagN <= op_a[DATA_W-1] | op_b[DATA_W-1];
              end
              OP_XOR: begin
                acc   <= op_a ^ op_b;
                FlagC <= 1'b0;
                FlagZ <= ~|(op_a ^ op_b);
                FlagN <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
              end
              OP_CMPE: FlagZ <= (op_a == op_b);
              OP_CMPL: FlagZ <= (op_a < op_b);
              OP_CMPG: FlagZ <= (op_a > op_b);
              OP_SHL, OP_SHR: begin
                if (sh_amt == '0) begin
                  // Zero-length shift: Acc unchanged, flags from it, no carry.
                  FlagC <= 1'b0;
                  FlagZ <= ~|acc;
                  FlagN <= acc[DATA_W-1];
                end else begin
                  OpDone  <= 1'b0;
                  work    <= acc;
                  cnt     <= CNT_W'(sh_amt);
                  shl_dir <= (OpCode == OP_SHL);
                  state   <= S_SHIFT;
                end
              end
              OP_MUL: begin
                OpDone <= 1'b0;
                mcand  <= op_a;
                prod   <= {{DATA_W{1'b0}}, op_b};
                cnt    <= CNT_W'(DATA_W);
                state  <= S_MUL;
              end
              OP_OEACC: begin
                OutData  <= acc;
                OutValid <= 1'b1;
              end
              OP_CLRE: FlagE <= 1'b0;
              default: FlagE <= 1'b1;
            endcase
          end
        end
        S_SHIFT: begin
          // Shift the working copy; Acc and flags change only on the last step.
          work <= work_sh;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            acc    <= work_sh;
            FlagC  <= sh_out;
            FlagZ  <= ~|work_sh;
            FlagN  <= work_sh[DATA_W-1];
            OpDone <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_MUL: begin
          prod <= prod_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            acc    <= prod_nx[DATA_W-1:0];
            FlagC  <= |prod_nx[2*DATA_W-1:DATA_W];
            FlagZ  <= ~|prod_nx[DATA_W-1:0];
            FlagN  <= prod_nx[DATA_W-1];
            OpDone <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: directed scenarios plus randomized operations,
// checked against an arithmetic reference model of the register file,
// accumulator, index and flags.
module tb_alu_mc;

  localparam int W  = 8;
  localparam int NR = 4;
  localparam int SW = $clog2(NR);
  localparam longint MOD = longint'(1) << W;

  // ---------------- clock / reset ----------------
  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic          OpValid = 1'b0;
  logic [4:0]    OpCode = '0;
  logic [SW-1:0] RegSel = '0;
  logic [W-1:0]  InData = '0;
  logic          OpReady, OpDone, OutValid;
  logic [W-1:0]  OutData, Index_Reg;
  logic          FlagZ, FlagC, FlagN, FlagE;
  logic [1:0]    DbgState;

  always #5 Clk = ~Clk;

  alu_mc #(.DATA_W(W), .NREGS(NR)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .OpValid(OpValid), .OpReady(OpReady),
    .OpCode(OpCode), .RegSel(RegSel), .InData(InData), .OpDone(OpDone),
    .OutData(OutData), .OutValid(OutValid), .Index_Reg(Index_Reg),
    .FlagZ(FlagZ), .FlagC(FlagC), .FlagN(FlagN), .FlagE(FlagE),
    .DbgState(DbgState)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] m_regs [NR];
  logic [W-1:0] m_acc, m_idx;
  logic         m_z, m_c, m_n, m_e;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every bus-output cycle must match the next expected OEACC value.
  always @(negedge Clk) begin
    if (Rst_n && OutValid) begin
      if (exp_q.size() == 0) check_val("out_spurious", OutValid, 0);
      else check_val("out_data", OutData, exp_q.pop_front());
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_acc = '0; m_idx = '0;
    m_z = 0; m_c = 0; m_n = 0; m_e = 0;
    exp_q.delete();
  endtask

  task automatic set_zn();
    m_z = (m_acc == '0);
    m_n = m_acc[W-1];
  endtask

  // Reference model: applies one accepted op; returns expected commit latency.
  task automatic model_apply(input logic [4:0] op, input int sel, input logic [W-1:0] d, output int lat);
    longint a, b, r;
    int k;
    a = longint'(m_regs[0]);
    b = longint'(m_regs[sel]);
    r = longint'(m_acc);
    k = int'(d) % W;
    lat = 0;
    case (op)
      5'd0: ;
      5'd1: m_regs[sel] = d;
      5'd2: m_acc = d;
      5'd3: m_idx = d;
      5'd4: m_regs[sel] = m_acc;
      5'd5: m_idx = m_acc;
      5'd6: begin m_c = (a + b) >= MOD; m_acc = W'((a + b) % MOD); set_zn(); end
      5'd7: begin m_c = (a < b); m_acc = W'((a - b + MOD) % MOD); set_zn(); end
      5'd8: begin m_c = 0; m_acc = W'(a & b); set_zn(); end
      5'd9: begin m_c = 0; m_acc = W'(a | b); set_zn(); end
      5'd10: begin m_c = 0; m_acc = W'(a ^ b); set_zn(); end
      5'd11: m_z = (a == b);
      5'd12: m_z = (a < b);
      5'd13: m_z = (a > b);
      5'd14: begin
        m_c = (k == 0) ? 1'b0 : 1'(r >> (W - k));
        m_acc = W'((r << k) % MOD); set_zn(); lat = k;
      end
      5'd15: begin
        m_c = (k == 0) ? 1'b0 : 1'(r >> (k - 1));
        m_acc = W'(r >> k); set_zn(); lat = k;
      end
      5'd16: begin
        m_c = (a * b) >= MOD; m_acc = W'((a * b) % MOD); set_zn(); lat = W;
      end
      5'd17: exp_q.push_back(m_acc);
      5'd18: m_e = 0;
      default: m_e = 1;
    endcase
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_z"}, FlagZ, m_z);
    check_val({tag, "_c"}, FlagC, m_c);
    check_val({tag, "_n"}, FlagN, m_n);
    check_val({tag, "_e"}, FlagE, m_e);
    check_val({tag, "_idx"}, Index_Reg, m_idx);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge where OpDone is seen.
  task automatic do_op(input logic [4:0] op, input int sel, input logic [W-1:0] d);
    int lat, exp_lat, waited;
    OpValid = 1'b1; OpCode = op; RegSel = SW'(sel); InData = d;
    waited = 0;
    while (!OpReady && waited < 100) begin @(negedge Clk); waited++; end
    if (!OpReady) check_val("ready_timeout", OpReady, 1);
    @(posedge Clk);
    model_apply(op, sel, d, exp_lat);
    @(negedge Clk);
    OpValid = 1'b0; OpCode = 5'($urandom_range(0, 31)); InData = W'($urandom);
    lat = 0;
    while (!OpDone && lat < 100) begin
      check_val("busy_ready", OpReady, 0);
      @(negedge Clk);
      lat++;
    end
    check_val($sformatf("latency_op%0d", op), lat, exp_lat);
    check_state($sformatf("op%0d", op));
  endtask

  task automatic idle_cycle();
    @(negedge Clk);
    check_val("idle_done", OpDone, 0);
    check_val("idle_outvalid", OutValid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_lat, lat;
    logic [4:0] rop;
    #2 Rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_val("rst_ready", OpReady, 1);
    check_val("rst_done", OpDone, 0);
    check_val("rst_outvalid", OutValid, 0);
    check_val("rst_outdata", OutData, 0);
    check_state("rst");
    Rst_n = 1'b1;

    // ADD / SUB with carry, borrow and negative
    do_op(5'd1, 0, 8'hF0);
    do_op(5'd1, 1, 8'h20);
    do_op(5'd6, 1, 8'h00);
    check_val("add_c_const", FlagC, 1);
    do_op(5'd17, 0, 8'h00);
    do_op(5'd7, 1, 8'h00);
    check_val("sub_n_const", FlagN, 1);
    do_op(5'd17, 0, 8'h00);

    // Shifts: k=3 left, then k=0 right
    do_op(5'd2, 0, 8'h81);
    do_op(5'd14, 0, 8'h03);
    do_op(5'd17, 0, 8'h00);
    do_op(5'd15, 0, 8'h00);
    do_op(5'd17, 0, 8'h00);
    do_op(5'd15, 0, 8'h07);
    do_op(5'd17, 0, 8'h00);

    // MUL with overflow
    do_op(5'd1, 0, 8'h10);
    do_op(5'd1, 2, 8'h11);
    do_op(5'd16, 2, 8'h00);
    do_op(5'd17, 0, 8'h00);

    // MUL with OpValid held: the next op waits until OpReady returns
    OpValid = 1'b1; OpCode = 5'd16; RegSel = SW'(2); InData = '0;
    @(posedge Clk);
    model_apply(5'd16, 2, 8'h00, exp_lat);
    @(negedge Clk);
    OpCode = 5'd2; RegSel = '0; InData = 8'h3C;
    lat = 0;
    while (!OpDone && lat < 100) begin @(negedge Clk); lat++; end
    check_val("held_mul_latency", lat, exp_lat);
    check_state("held_mul");
    @(posedge Clk);
    model_apply(5'd2, 0, 8'h3C, exp_lat);
    @(negedge Clk);
    OpValid = 1'b0;
    check_val("held_ld_done", OpDone, 1);
    do_op(5'd17, 0, 8'h00);

    // Compares
    do_op(5'd1, 0, 8'h05);
    do_op(5'd1, 1, 8'h07);
    do_op(5'd12, 1, 8'h00);
    do_op(5'd13, 1, 8'h00);
    do_op(5'd11, 1, 8'h00);
    do_op(5'd17, 0, 8'h00);

    // Error flag is sticky until CLRE
    do_op(5'd25, 0, 8'h00);
    do_op(5'd6, 1, 8'h00);
    do_op(5'd18, 0, 8'h00);

    // OEACC pulse lasts one cycle
    do_op(5'd2, 0, 8'h5A);
    do_op(5'd17, 0, 8'h00);
    idle_cycle();

    // Index and moves
    do_op(5'd3, 0, 8'hA5);
    do_op(5'd5, 0, 8'h00);
    do_op(5'd4, 3, 8'h00);

    // Reset in the middle of MUL aborts it
    do_op(5'd31, 0, 8'h00);
    do_op(5'd1, 0, 8'hFF);
    do_op(5'd1, 2, 8'hFF);
    OpValid = 1'b1; OpCode = 5'd16; RegSel = SW'(2);
    @(posedge Clk);
    @(negedge Clk);
    OpValid = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b0;
    model_reset();
    #1;
    check_val("midrst_ready", OpReady, 1);
    check_val("midrst_done", OpDone, 0);
    check_val("midrst_outvalid", OutValid, 0);
    check_val("midrst_outdata", OutData, 0);
    check_state("midrst");
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) idle_cycle();
    do_op(5'd17, 0, 8'h00);
    do_op(5'd6, 2, 8'h00);

    // Randomized operations
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rop = 5'($urandom_range(19, 31));
      else rop = 5'($urandom_range(0, 18));
      do_op(rop, $urandom_range(0, NR - 1), W'($urandom));
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end

    repeat (2) @(negedge Clk);
    check_val("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
